// File: rtl/enc16_4_serial.sv
// Serial priority encoder: accepts a request vector and emits the index of each
// set bit, lowest first, one per output handshake.
module enc16_4_serial #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2**W-1:0]  req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     idx,
  output logic             last,
  output logic [W:0]       remaining,
  output logic             zero_err,
  input  logic             flush
);

  localparam int N = 2**W;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           zero_err_q, zero_err_d;
  logic [W-1:0]   low_idx;
  logic [W:0]     pend_cnt;

  // Downward scan so the lowest set bit is the one left standing.
  always_comb begin
    low_idx  = '0;
    pend_cnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      pend_cnt = pend_cnt + (W + 1)'(pend_q[i]);
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SERVE);
    idx       = (state_q == SERVE) ? low_idx : '0;
    last      = (state_q == SERVE) && (pend_cnt == (W + 1)'(1));
    remaining = (state_q == SERVE) ? pend_cnt : '0;
    zero_err  = zero_err_q;
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    zero_err_d = 1'b0;
    if (flush) begin
      pend_d  = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (req != '0) begin
              pend_d  = req;
              state_d = SERVE;
            end else begin
              zero_err_d = 1'b1;
            end
          end
        end
        SERVE: begin
          if (out_ready) begin
            pend_d[low_idx] = 1'b0;
            if (last) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          pend_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule
